// File: rtl/wsa_pkg.sv
// Shared types and default sizing for the word stream arbiter.
package wsa_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_BURST_LEN = 16;
   localparam int DEF_DATA_W    = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
   import wsa_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win
);

   logic found;
   int   idx;

   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/word_stream_arbiter.sv
// Grants one requester at a time a burst of words into a downstream buffer.
// Optional WSA_PRIO0_EN: requester 0 wins every arbitration it takes part in.
module word_stream_arbiter
   import wsa_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      buf_ready_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      valid_pulse_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr, gidx, ptr_nxt;
   logic [CNT_W-1:0]    beat_cnt;
   logic [NUM_REQ-1:0]  grant_q, rr_win, win;
   logic [DATA_W-1:0]   data_q, sel_data;
   logic                pulse_q, sel_valid, sel_last, beat, burst_done, rel, start;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req (req_valid_i),
      .ptr (rr_ptr),
      .win (rr_win)
   );

`ifdef WSA_PRIO0_EN
   assign win = req_valid_i[0] ? NUM_REQ'(1) : rr_win;
`else
   assign win = rr_win;
`endif

   always_comb begin
      gidx = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (grant_q[k]) gidx = PTR_W'(k);
   end

   assign sel_valid  = req_valid_i[gidx];
   assign sel_last   = req_last_i[gidx];
   assign sel_data   = req_data_i[int'(gidx)*DATA_W +: DATA_W];
   assign busy_o     = (state_q == XFER);
   assign beat       = busy_o && sel_valid && buf_ready_i;
   assign burst_done = (beat_cnt == CNT_W'(BURST_LEN - 1));
   // A dropped valid ends the grant even while the buffer is stalling.
   assign rel        = busy_o && ((beat && (sel_last || burst_done)) || !sel_valid);
   assign start      = (state_q == IDLE) && (|req_valid_i);
   assign ptr_nxt    = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

   assign req_ready_o   = busy_o ? (grant_q & {NUM_REQ{buf_ready_i}}) : '0;
   assign grant_o       = grant_q;
   assign data_o        = data_q;
   assign valid_pulse_o = pulse_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = XFER;
         XFER:    if (rel)   state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant_q  <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         data_q   <= '0;
         pulse_q  <= 1'b0;
      end else begin
         pulse_q <= beat;
         if (beat) begin
            data_q   <= sel_data;
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (start) begin
            grant_q  <= win;
            beat_cnt <= '0;
         end else if (rel) begin
            grant_q <= '0;
            rr_ptr  <= ptr_nxt;
         end
      end
   end

endmodule
